// File: rtl/downsampler_mac_sched.sv
// Shared-MAC scheduler for a two-stage downsampler: round-robin grants one
// requester at a time and sequences its taps, pipeline drain and done pulse.
module downsampler_mac_sched #(
   parameter int unsigned TAPS0 = 17,
   parameter int unsigned TAPS1 = 48,
   parameter int unsigned PIPE  = 3,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          en,
   input  logic [1:0]    req,
   input  logic          clr_ovf,
   output logic [1:0]    grant,
   output logic [AW-1:0] tap_addr,
   output logic          mac_vld,
   output logic          mac_first,
   output logic [1:0]    done,
   output logic          busy,
   output logic [1:0]    ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int unsigned DW = (PIPE > 1) ? $clog2(PIPE) : 1;
   localparam logic [AW-1:0] LAST0 = AW'(TAPS0 - 1);
   localparam logic [AW-1:0] LAST1 = AW'(TAPS1 - 1);
   localparam logic [DW-1:0] DLAST = DW'((PIPE > 0) ? PIPE - 1 : 0);

   state_t        state_q, state_d;
   logic [1:0]    grant_q, grant_d;
   logic [AW-1:0] tap_q, tap_d;
   logic [DW-1:0] drn_q, drn_d;
   logic [1:0]    pending_q, pending_d;
   logic [1:0]    ovf_q, ovf_d;
   logic          last_q, last_d;

   logic [1:0]    req_v, cand, pick, ovf_evt;
   logic          take;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      tap_d     = tap_q;
      drn_d     = drn_q;
      pending_d = pending_q;
      ovf_d     = ovf_q;
      last_d    = last_q;
      take      = 1'b0;
      mac_vld   = 1'b0;
      mac_first = 1'b0;
      done      = 2'b00;

      req_v   = en ? req : 2'b00;
      cand    = pending_q | req_v;
      // last_q=1 means requester 1 was served last, so requester 0 wins a tie
      pick    = (cand == 2'b11) ? (last_q ? 2'b01 : 2'b10) : cand;
      ovf_evt = req_v & pending_q;

      if (en) begin
         pending_d = pending_q | req_v;
         ovf_d     = (ovf_q & ~{2{clr_ovf}}) | ovf_evt;
         case (state_q)
            IDLE: begin
               if (|cand) take = 1'b1;
            end
            RUN: begin
               mac_vld   = 1'b1;
               mac_first = (tap_q == '0);
               if (tap_q == (grant_q[1] ? LAST1 : LAST0)) begin
                  tap_d   = '0;
                  drn_d   = '0;
                  state_d = (PIPE == 0) ? DONE : DRAIN;
               end else begin
                  tap_d = tap_q + 1'b1;
               end
            end
            DRAIN: begin
               if (drn_q == DLAST) state_d = DONE;
               else                drn_d   = drn_q + 1'b1;
            end
            DONE: begin
               done = grant_q;
               if (|cand) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
                  grant_d = 2'b00;
               end
            end
            default: state_d = IDLE;
         endcase

         if (take) begin
            state_d   = RUN;
            grant_d   = pick;
            tap_d     = '0;
            pending_d = (pending_q | req_v) & ~pick;
            last_d    = pick[1];
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= IDLE;
         grant_q   <= 2'b00;
         tap_q     <= '0;
         drn_q     <= '0;
         pending_q <= 2'b00;
         ovf_q     <= 2'b00;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         tap_q     <= tap_d;
         drn_q     <= drn_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         last_q    <= last_d;
      end
   end

   assign grant    = grant_q;
   assign tap_addr = tap_q;
   assign busy     = (state_q != IDLE);
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_downsampler_mac_sched.sv
// Directed bench for downsampler_mac_sched with TAPS0=17, TAPS1=48, PIPE=3.
module tb_downsampler_mac_sched;

   logic       clk;
   logic       arst_n;
   logic       en;
   logic [1:0] req;
   logic       clr_ovf;
   logic [1:0] grant;
   logic [5:0] tap_addr;
   logic       mac_vld;
   logic       mac_first;
   logic [1:0] done;
   logic       busy;
   logic [1:0] ovf;

   int nchecks = 0;
   int nerrors = 0;

   downsampler_mac_sched #(
      .TAPS0(17),
      .TAPS1(48),
      .PIPE (3),
      .AW   (6)
   ) dut (
      .clk      (clk),
      .arst_n   (arst_n),
      .en       (en),
      .req      (req),
      .clr_ovf  (clr_ovf),
      .grant    (grant),
      .tap_addr (tap_addr),
      .mac_vld  (mac_vld),
      .mac_first(mac_first),
      .done     (done),
      .busy     (busy),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string p, input int c, input logic [1:0] eg, input int et,
                             input logic ev, input logic ef, input logic [1:0] ed, input logic eb);
      check($sformatf("%s c%0d grant", p, c), 32'(grant), 32'(eg));
      check($sformatf("%s c%0d tap_addr", p, c), 32'(tap_addr), 32'(et));
      check($sformatf("%s c%0d mac_vld", p, c), 32'(mac_vld), 32'(ev));
      check($sformatf("%s c%0d mac_first", p, c), 32'(mac_first), 32'(ef));
      check($sformatf("%s c%0d done", p, c), 32'(done), 32'(ed));
      check($sformatf("%s c%0d busy", p, c), 32'(busy), 32'(eb));
   endtask

   // Expected outputs of an unstalled burst whose tap 0 is at cycle s.
   task automatic exp_burst(input string p, input int c, input int s, input int t,
                            input logic [1:0] g);
      logic act, v;
      act = (c >= s) && (c <= s + t + 3);
      v   = (c >= s) && (c < s + t);
      check_outs(p, c, act ? g : 2'b00, v ? c - s : 0, v, c == s,
                 (c == s + t + 3) ? g : 2'b00, act);
   endtask

   task automatic do_reset();
      arst_n  = 1'b0;
      en      = 1'b1;
      req     = 2'b00;
      clr_ovf = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_outs("RST", 0, 2'b00, 0, 1'b0, 1'b0, 2'b00, 1'b0);
      check("RST ovf", 32'(ovf), 32'd0);
      arst_n = 1'b1;
   endtask

   initial begin
      // single requester-0 burst
      do_reset();
      for (int c = 0; c <= 22; c++) begin
         @(negedge clk);
         req = (c == 0) ? 2'b01 : 2'b00;
         #1;
         exp_burst("A", c, 1, 17, 2'b01);
      end

      // simultaneous requests, back-to-back bursts
      do_reset();
      for (int c = 0; c <= 74; c++) begin
         @(negedge clk);
         req = (c == 0) ? 2'b11 : 2'b00;
         #1;
         if (c < 22) exp_burst("B", c, 1, 17, 2'b01);
         else        exp_burst("B", c, 22, 48, 2'b10);
      end

      // five-cycle enable stall at tap 4
      do_reset();
      for (int c = 0; c <= 27; c++) begin
         logic v;
         int   et;
         @(negedge clk);
         req = (c == 0) ? 2'b01 : 2'b00;
         en  = !(c >= 5 && c <= 9);
         #1;
         v  = ((c >= 1) && (c <= 4)) || ((c >= 10) && (c <= 22));
         et = (c >= 1 && c <= 4) ? c - 1 : (c >= 5 && c <= 9) ? 4 : (c >= 10 && c <= 22) ? c - 6 : 0;
         check_outs("C", c, (c >= 1 && c <= 26) ? 2'b01 : 2'b00, et, v, c == 1,
                    (c == 26) ? 2'b01 : 2'b00, c >= 1 && c <= 26);
      end
      en = 1'b1;

      // overflow while requester 1 bursts, then a single requester-0 burst
      do_reset();
      for (int c = 0; c <= 80; c++) begin
         @(negedge clk);
         req     = (c == 0) ? 2'b10 : (c == 5 || c == 10 || c == 40) ? 2'b01 : 2'b00;
         clr_ovf = (c == 30 || c == 40 || c == 45);
         #1;
         if (c < 53) exp_burst("D", c, 1, 48, 2'b10);
         else        exp_burst("D", c, 53, 17, 2'b01);
         if (c == 10) check("D ovf before", 32'(ovf), 32'd0);
         if (c == 11) check("D ovf set", 32'(ovf), 32'd1);
         if (c == 30) check("D ovf held", 32'(ovf), 32'd1);
         if (c == 31) check("D ovf cleared", 32'(ovf), 32'd0);
         if (c == 41) check("D ovf clr+event", 32'(ovf), 32'd1);
         if (c == 46) check("D ovf cleared2", 32'(ovf), 32'd0);
      end
      clr_ovf = 1'b0;

      // reset mid-burst at tap 10, then a requester-1 burst
      do_reset();
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         req = (c == 0) ? 2'b01 : 2'b00;
         #1;
         exp_burst("E", c, 1, 17, 2'b01);
      end
      arst_n = 1'b0;
      #1;
      check_outs("E rst", 11, 2'b00, 0, 1'b0, 1'b0, 2'b00, 1'b0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1;
         check_outs("E rsthold", c, 2'b00, 0, 1'b0, 1'b0, 2'b00, 1'b0);
      end
      arst_n = 1'b1;
      for (int c = 0; c <= 54; c++) begin
         @(negedge clk);
         req = (c == 0) ? 2'b10 : 2'b00;
         #1;
         exp_burst("E2", c, 1, 48, 2'b10);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
